pwm_setting_ctrl: RTL

//  Turns three raw push-buttons (up, down, mode) into the PWM setting registers.

---
 rtl/pwm_setting_ctrl_pkg.sv | 35 +++
 rtl/pwm_setting_ctrl_if.sv | 15 +
 rtl/pwm_setting_ctrl_btn_debounce.sv | 102 ++++++++++
 rtl/pwm_setting_ctrl.sv | 65 ++++++
 4 files changed

// File: rtl/pwm_setting_ctrl_pkg.sv
// Shared limits, debounce state encoding and step helpers for the PWM setting controller.
package pwm_pkg;

  localparam int BF_MIN = 1;
  localparam int BF_MAX = 8;
  localparam int BC_MIN = 0;
  localparam int BC_MAX = 10;

  localparam int DEF_DEB_CYCLES = 500000;
  localparam int DEF_REPEAT_DLY = 25000000;
  localparam int DEF_REPEAT_PER = 10000000;
  localparam int DEF_BF_RST     = 1;
  localparam int DEF_BC_RST     = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_P = 2'd1,
    HELD   = 2'd2,
    WAIT_R = 2'd3
  } deb_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One saturating step toward hi (inc=1) or lo (inc=0); never wraps.
  function automatic logic [3:0] step_sat(input logic [3:0] v, input logic inc,
                                          input logic [3:0] lo, input logic [3:0] hi);
    if (inc) return (v >= hi) ? v : v + 4'd1;
    return (v <= lo) ? v : v - 4'd1;
  endfunction

endpackage

// File: rtl/pwm_setting_ctrl_if.sv
// Button inputs and setting outputs of the PWM setting controller.
interface pwm_setting_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_mode;
  logic [3:0] bf;
  logic [3:0] bc;
  logic       opcion;
  logic       cambio;

  modport master (output btn_up, btn_down, btn_mode,
                  input  bf, bc, opcion, cambio);
  modport slave  (input  btn_up, btn_down, btn_mode,
                  output bf, bc, opcion, cambio);
endinterface

// File: rtl/pwm_setting_ctrl_btn_debounce.sv
// Per-button synchronizer, debounce FSM and hold auto-repeat; emits registered step pulses.
module btn_debounce
  import pwm_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int MAXP = max3(DEB_CYCLES, REPEAT_DLY, REPEAT_PER);
  localparam int CW   = (MAXP > 2) ? $clog2(MAXP) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

  logic          sync1_q, sync2_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep_q, rep_d;
  logic          pulse_q, pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      pulse_q <= pulse_d;
    end
  end

  // In HELD the counter is reused as the repeat timer; rep_q selects first delay vs period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = WAIT_P;
          cnt_d   = CW'(1);
        end
      end
      WAIT_P: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = HELD;
          pulse_d = 1'b1;
          cnt_d   = '0;
          rep_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = WAIT_R;
          cnt_d   = CW'(1);
        end else if (REPEAT_EN) begin
          if (cnt_q >= (rep_q ? PER_LAST : DLY_LAST)) begin
            pulse_d = 1'b1;
            cnt_d   = '0;
            rep_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WAIT_R: begin
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
          rep_d   = 1'b0;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/pwm_setting_ctrl.sv
// PWM setting registers: debounced up/down/mode buttons drive saturating bf/bc and the mode flag.
module pwm_setting_ctrl
  import pwm_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER,
  parameter int BF_RST     = DEF_BF_RST,
  parameter int BC_RST     = DEF_BC_RST
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_setting_ctrl_if.slave  bus
);

  logic       up_p, dn_p, md_p;
  logic [3:0] bf_q, bf_d;
  logic [3:0] bc_q, bc_d;
  logic       opcion_q, opcion_d;
  logic       cambio_q, cambio_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_DLY(REPEAT_DLY),
                 .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b1))
    u_up   (.clk(clk), .rst_n(rst_n), .btn_i(bus.btn_up),   .pulse_o(up_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_DLY(REPEAT_DLY),
                 .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b1))
    u_down (.clk(clk), .rst_n(rst_n), .btn_i(bus.btn_down), .pulse_o(dn_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_DLY(REPEAT_DLY),
                 .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b0))
    u_mode (.clk(clk), .rst_n(rst_n), .btn_i(bus.btn_mode), .pulse_o(md_p));

  // Mode pulse wins over up/down; up+down together cancel.
  always_comb begin
    bf_d     = bf_q;
    bc_d     = bc_q;
    opcion_d = opcion_q;
    if (md_p) begin
      opcion_d = ~opcion_q;
    end else if (up_p ^ dn_p) begin
      if (opcion_q) bf_d = step_sat(bf_q, up_p, 4'(BF_MIN), 4'(BF_MAX));
      else          bc_d = step_sat(bc_q, up_p, 4'(BC_MIN), 4'(BC_MAX));
    end
    cambio_d = (bf_d != bf_q) || (bc_d != bc_q) || (opcion_d != opcion_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_q     <= 4'(BF_RST);
      bc_q     <= 4'(BC_RST);
      opcion_q <= 1'b1;
      cambio_q <= 1'b0;
    end else begin
      bf_q     <= bf_d;
      bc_q     <= bc_d;
      opcion_q <= opcion_d;
      cambio_q <= cambio_d;
    end
  end

  assign bus.bf     = bf_q;
  assign bus.bc     = bc_q;
  assign bus.opcion = opcion_q;
  assign bus.cambio = cambio_q;

endmodule
